// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the data-memory responder and the
// word RAM it wraps.
//   mem_state_t      : responder FSM states (IDLE, WAIT, RESP)
//   ARQ_DEFAULT      : default data word width
//   MEM_ADDR_DEFAULT : default word-address width
//   LAT_W            : width of the latency counter (LATENCY is 1..15)
//   mem_req_t        : captured request {we, addr, wdata} at the default widths
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int ARQ_DEFAULT      = 16;
  localparam int MEM_ADDR_DEFAULT = 13;
  localparam int LAT_W            = 4;

  typedef struct packed {
    logic                        we;
    logic [MEM_ADDR_DEFAULT-1:0] addr;
    logic [ARQ_DEFAULT-1:0]      wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: synchronous single-port word RAM, registered read port.
// Ports:
//   clk   in   clock
//   en    in   access enable
//   we    in   1 = write wdata to addr, 0 = read addr into rdata
//   addr  in   [ADDR_W-1:0] word address
//   wdata in   [DATA_W-1:0] write data
//   rdata out  [DATA_W-1:0] read data, updated on the edge after a read;
//              held across writes and idle cycles
// Contents and rdata are not reset.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: data-memory target for the MEM stage. Accepts one load/store
// at a time over req_valid/req_ready, waits LATENCY cycles, commits the access
// and presents the result over rsp_valid/rsp_ready.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   [MEMORY_ADDR_SIZE-1:0] word address
//   req_wdata  in   [ARQ-1:0] store data
//   rsp_valid  out  response present (RESP)
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  [ARQ-1:0] load data, or the stored word for stores
//   busy       out  any state other than IDLE
// Optional (macro MEM_RESPONDER_STATS_EN):
//   stat_loads / stat_stores  out [15:0] committed loads / stores, saturating
//   stat_stall                out [15:0] cycles with rsp_valid && !rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter int ARQ              = ARQ_DEFAULT,
  parameter int MEMORY_ADDR_SIZE = MEM_ADDR_DEFAULT,
  parameter int LATENCY          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [MEMORY_ADDR_SIZE-1:0] req_addr,
  input  logic [ARQ-1:0]              req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ARQ-1:0]              rsp_rdata,
  output logic                        busy
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]                 stat_loads,
  output logic [15:0]                 stat_stores,
  output logic [15:0]                 stat_stall
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("mem_responder: LATENCY must be in 1..15");
  end

  typedef struct packed {
    logic                        we;
    logic [MEMORY_ADDR_SIZE-1:0] addr;
    logic [ARQ-1:0]              wdata;
  } req_t;

  mem_state_t                  state, state_next;
  logic [LAT_W-1:0]            cnt;
  req_t                        cap;
  logic                        accept;
  logic                        commit;
  logic                        ram_en;
  logic                        ram_we;
  logic [MEMORY_ADDR_SIZE-1:0] ram_addr;
  logic [ARQ-1:0]              ram_rdata;

  assign accept = (state == IDLE) && req_valid;
  assign commit = (state == WAIT) && (cnt == '0);

  // Loads read the RAM on the acceptance edge so the registered read data is
  // ready by the commit edge even with LATENCY=1; accesses are serialized, so
  // nothing can write the word in between. Stores write on the commit edge,
  // so a reset during WAIT leaves memory untouched.
  assign ram_en   = (accept && !req_we) || (commit && cap.we);
  assign ram_we   = commit && cap.we;
  assign ram_addr = (state == IDLE) ? req_addr : cap.addr;

  mem_array #(
    .DATA_W (ARQ),
    .ADDR_W (MEMORY_ADDR_SIZE)
  ) u_mem_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cap.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      cap       <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cap       <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        cnt       <= LAT_W'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) rsp_rdata <= cap.we ? cap.wdata : ram_rdata;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_stall  <= '0;
    end else begin
      if (commit && !cap.we && stat_loads != '1)  stat_loads  <= stat_loads + 1'b1;
      if (commit && cap.we && stat_stores != '1)  stat_stores <= stat_stores + 1'b1;
      if (rsp_valid && !rsp_ready && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int DW  = 16;
  localparam int AW  = 13;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0]   stat_loads;
  logic [15:0]   stat_stores;
  logic [15:0]   stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  // reference memory: only addresses ever stored are known
  logic [DW-1:0] model [int];
  int            addr_q [$];

  mem_responder #(
    .ARQ              (DW),
    .MEMORY_ADDR_SIZE (AW),
    .LATENCY          (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!model.exists(int'(a))) addr_q.push_back(int'(a));
    model[int'(a)] = d;
  endtask

  // One full transaction: accept, LAT cycles of WAIT, RESP held for 'stall'
  // cycles with rsp_ready low, then release. Inputs are scrambled throughout.
  task automatic do_txn(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int stall);
    logic [DW-1:0] exp;
    exp = we ? d : model[int'(a)];
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = (stall == 0);
    tick();
    for (int k = 0; k < LAT; k++) begin
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("wait_no_valid", {31'd0, rsp_valid}, 32'd0);
      check("wait_not_ready", {31'd0, req_ready}, 32'd0);
      scramble();
      tick();
    end
    check("rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp});
    for (int s = 0; s < stall; s++) begin
      scramble();
      tick();
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rdata", {16'd0, rsp_rdata}, {16'd0, exp});
      check("stall_not_ready", {31'd0, req_ready}, 32'd0);
    end
    if (we) model_write(a, d);
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    tick();
    check("back_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("back_idle_ready", {31'd0, req_ready}, 32'd1);
    check("back_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick();

    // store then load
    do_txn(1'b1, 13'h0005, 16'd17, 0);
    do_txn(1'b0, 13'h0005, 16'd0, 0);

    // backpressure on a load
    do_txn(1'b0, 13'h0005, 16'd0, 4);

    // input changes after acceptance
    do_txn(1'b1, 13'h1FFF, 16'hBEEF, 0);
    do_txn(1'b0, 13'h1FFF, 16'd0, 2);

    // reset during WAIT drops the store
    do_txn(1'b1, 13'h0010, 16'h1234, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 13'h0010;
    req_wdata = 16'hAAAA;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_pulse", {31'd0, rsp_valid}, 32'd0);
    end
    do_txn(1'b0, 13'h0010, 16'd0, 0);

    // reset while in RESP: store has committed, rsp_valid drops at once
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 13'h0020;
    req_wdata = 16'h55AA;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (LAT) tick();
    check("resp_before_rst", {31'd0, rsp_valid}, 32'd1);
    model_write(13'h0020, 16'h55AA);
    rst = 1'b0;
    #1;
    check("resp_async_drop", {31'd0, rsp_valid}, 32'd0);
    check("resp_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    do_txn(1'b0, 13'h0020, 16'd0, 0);

    // randomized traffic over a small address pool, with boundary addresses
    pool[0] = '0;
    pool[1] = '1;
    for (int i = 2; i < 8; i++) pool[i] = AW'($urandom);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_txn(1'b1, pool[$urandom_range(0, 7)], DW'($urandom), $urandom_range(0, 3));
      else
        do_txn(1'b0, AW'(addr_q[$urandom_range(0, addr_q.size() - 1)]), '0, $urandom_range(0, 3));
    end

    // every stored address still holds its last value
    for (int i = 0; i < addr_q.size(); i++)
      do_txn(1'b0, AW'(addr_q[i]), '0, 0);

`ifdef MEM_RESPONDER_STATS_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_txn(1'b0, 13'h0005, '0, 0);
    do_txn(1'b1, 13'h0030, 16'h0101, 0);
    do_txn(1'b0, 13'h0030, '0, 5);
    do_txn(1'b1, 13'h0031, 16'h0202, 0);
    do_txn(1'b0, 13'h0031, '0, 0);
    check("stat_loads", {16'd0, stat_loads}, 32'd3);
    check("stat_stores", {16'd0, stat_stores}, 32'd2);
    check("stat_stall", {16'd0, stat_stall}, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
